// File: rtl/tlb_pkg.sv
// Shared types and default geometry for the translation stage in front of the cache.
// The default widths give 12-bit VPNs and 6-bit PPNs, so {PPN, offset} forms a 10-bit cache address.
package tlb_pkg;

  localparam int VA_W      = 16;
  localparam int PA_W      = 10;
  localparam int OFF_W     = 4;
  localparam int N_ENTRIES = 4;

  localparam int VPN_W = VA_W - OFF_W;
  localparam int PPN_W = PA_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_cam.sv
// Fully associative VPN->PPN store with one write port and a combinational lookup.
// When several entries match, the lowest index wins. A flush clears every valid bit and takes priority over a write.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int ENTRIES = N_ENTRIES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic [VPN_W-1:0]           i_lookup_vpn,
  output logic                       o_hit,
  output logic [PPN_W-1:0]           o_hit_ppn,
  output logic [$clog2(ENTRIES)-1:0] o_hit_index,
  input  logic                       i_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
  input  tlb_entry_t                 i_wr_entry
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [VPN_W-1:0]   r_vpn [ENTRIES];
  logic [PPN_W-1:0]   r_ppn [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_entry.valid;
    end
  end

  // NOTE: only the valid bits are reset; tag/data contents are don't-care while invalid,
  // so they live in a reset-free block and can map onto plain storage.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_vpn[i_wr_idx] <= i_wr_entry.vpn;
      r_ppn[i_wr_idx] <= i_wr_entry.ppn;
    end
  end

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    o_hit       = 1'b0;
    o_hit_ppn   = '0;
    o_hit_index = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_vpn[i] == i_lookup_vpn)) begin
        o_hit       = 1'b1;
        o_hit_ppn   = r_ppn[i];
        o_hit_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_translate.sv
// Translation stage in front of the cache: TLB lookup, page-table walk on miss, round-robin refill.
// Define TLB_STATS_EN to add saturating hit/miss/fault counters as extra outputs.
module tlb_translate
  import tlb_pkg::*;
#(
  parameter int VA_WIDTH     = VA_W,
  parameter int PA_WIDTH     = PA_W,
  parameter int OFFSET_WIDTH = OFF_W,
  parameter int ENTRIES      = N_ENTRIES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req,
  input  logic [VA_WIDTH-1:0]              cpu_vaddr,
  input  logic                             cpu_write,
  input  logic [31:0]                      cpu_write_data,
  input  logic                             tlb_flush,
  output logic                             busy,
  output logic [PA_WIDTH-1:0]              cache_address,
  output logic                             cache_write,
  output logic [31:0]                      cache_write_data,
  output logic                             tlb_end,
  output logic                             tlb_fault,
`ifdef TLB_STATS_EN
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count,
  output logic [15:0]                      fault_count,
`endif
  output logic                             pt_req,
  output logic [VA_WIDTH-OFFSET_WIDTH-1:0] pt_vpn,
  input  logic                             pt_ack,
  input  logic                             pt_valid,
  input  logic [PA_WIDTH-OFFSET_WIDTH-1:0] pt_ppn
);

  localparam int IDX_W = $clog2(ENTRIES);

  state_t                  r_state;
  state_t                  w_next_state;

  logic [VPN_W-1:0]        r_vpn;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic                    r_write;
  logic [31:0]             r_wdata;
  logic [IDX_W-1:0]        r_rr;

  logic [PA_WIDTH-1:0]     r_cache_address;
  logic                    r_cache_write;
  logic [31:0]             r_cache_write_data;

  logic                    w_accept;
  logic                    w_cam_hit;
  logic                    w_hit;
  logic [PPN_W-1:0]        w_hit_ppn;
  logic [IDX_W-1:0]        w_unused_hit_index;
  logic                    w_walk_ack;
  logic                    w_fill;
  logic                    w_fault_ack;
  tlb_entry_t              w_fill_entry;

  assign w_accept    = (r_state == IDLE) && cpu_req;
  // A flush in the lookup cycle forces a miss even if the stale entry still matches.
  assign w_hit       = w_cam_hit && !tlb_flush;
  assign w_walk_ack  = (r_state == WALK) && pt_ack;
  assign w_fill      = w_walk_ack && pt_valid;
  assign w_fault_ack = w_walk_ack && !pt_valid;

  assign w_fill_entry = '{valid: 1'b1, vpn: r_vpn, ppn: pt_ppn};

  tlb_cam #(
    .ENTRIES (ENTRIES)
  ) u_cam (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (tlb_flush),
    .i_lookup_vpn (cpu_vaddr[VA_WIDTH-1:OFFSET_WIDTH]),
    .o_hit        (w_cam_hit),
    .o_hit_ppn    (w_hit_ppn),
    .o_hit_index  (w_unused_hit_index),
    .i_wr_en      (w_fill),
    .i_wr_idx     (r_rr),
    .i_wr_entry   (w_fill_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_next_state = w_hit ? RESP : WALK;
      WALK:    if (pt_ack)  w_next_state = pt_valid ? RESP : FAULT;
      RESP:    w_next_state = IDLE;
      FAULT:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    pt_req    = (r_state == WALK);
    pt_vpn    = (r_state == WALK) ? r_vpn : '0;
    tlb_end   = (r_state == RESP) || (r_state == FAULT);
    tlb_fault = (r_state == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpn    <= '0;
      r_offset <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_vpn    <= cpu_vaddr[VA_WIDTH-1:OFFSET_WIDTH];
      r_offset <= cpu_vaddr[OFFSET_WIDTH-1:0];
      r_write  <= cpu_write;
      r_wdata  <= cpu_write_data;
    end
  end

  // The replacement pointer advances on every successful walk, even when a concurrent flush drops the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_fill) begin
      r_rr <= r_rr + 1'b1;
    end
  end

  // Cache-facing outputs load only when a response is produced and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_address    <= '0;
      r_cache_write      <= 1'b0;
      r_cache_write_data <= '0;
    end else if (w_accept && w_hit) begin
      r_cache_address    <= {w_hit_ppn, cpu_vaddr[OFFSET_WIDTH-1:0]};
      r_cache_write      <= cpu_write;
      r_cache_write_data <= cpu_write_data;
    end else if (w_fill) begin
      r_cache_address    <= {pt_ppn, r_offset};
      r_cache_write      <= r_write;
      r_cache_write_data <= r_wdata;
    end else if (w_fault_ack) begin
      r_cache_address    <= '0;
      r_cache_write      <= 1'b0;
      r_cache_write_data <= r_wdata;
    end
  end

  assign cache_address    = r_cache_address;
  assign cache_write      = r_cache_write;
  assign cache_write_data = r_cache_write_data;

`ifdef TLB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count   <= '0;
      miss_count  <= '0;
      fault_count <= '0;
    end else begin
      if (w_accept && w_hit && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if (w_accept && !w_hit && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
      if (w_fault_ack && (fault_count != 16'hFFFF))
        fault_count <= fault_count + 16'd1;
    end
  end
`endif

endmodule
